// File: rtl/date_month.sv
// Day/month calendar counter with load validation and leap-year support.
// Advances one day per day_tick, rolls Dec 31 over to Jan 1 with a one-cycle
// year_inc pulse, and rejects impossible dates on load (load_err pulse).
// Optional feature macro: LEAP_YEAR_EN (Feb has 29 days when year[1:0] == 0).
module date_month (
   input  logic       clk,
   input  logic       clear,
   input  logic       day_tick,
   input  logic       load,
   input  logic [4:0] load_day,
   input  logic [3:0] load_month,
   input  logic [5:0] year,
   input  logic       enable,
   output logic [4:0] day,
   output logic [3:0] month,
   output logic       year_inc,
   output logic       load_err,
   output logic [4:0] day_bus,
   output logic [3:0] month_bus
);

   logic [4:0] day_reg, day_next;
   logic [3:0] month_reg, month_next;
   logic       year_inc_reg, year_inc_next;
   logic       load_err_reg, load_err_next;
   logic       leap;
   logic [4:0] dim_cur;
   logic [4:0] dim_load;
   logic       load_ok;

`ifdef LEAP_YEAR_EN
   // Only the two low bits of the year matter: multiples of four are leap.
   logic unused_year_hi;
   assign leap           = (year[1:0] == 2'd0);
   assign unused_year_hi = ^year[5:2];
`else
   // Without leap support February is always 28 days and year is ignored.
   logic unused_year;
   assign leap        = 1'b0;
   assign unused_year = ^year;
`endif

   function automatic logic [4:0] days_in_month(input logic [3:0] m, input logic lp);
      case (m)
         4'd2:                      return lp ? 5'd29 : 5'd28;
         4'd4, 4'd6, 4'd9, 4'd11:   return 5'd30;
         default:                   return 5'd31;
      endcase
   endfunction

   assign dim_cur  = days_in_month(month_reg, leap);
   assign dim_load = days_in_month(load_month, leap);
   assign load_ok  = (load_month >= 4'd1) && (load_month <= 4'd12) &&
                     (load_day >= 5'd1) && (load_day <= dim_load);

   // Next-state: load beats day_tick; a rollover uses >= so a Feb 29 made
   // invalid by a year change still advances to Mar 1.
   always_comb begin
      day_next      = day_reg;
      month_next    = month_reg;
      year_inc_next = 1'b0;
      load_err_next = 1'b0;
      if (load) begin
         if (load_ok) begin
            day_next   = load_day;
            month_next = load_month;
         end else begin
            load_err_next = 1'b1;
         end
      end else if (day_tick) begin
         if (day_reg < dim_cur) begin
            day_next = day_reg + 5'd1;
         end else begin
            day_next = 5'd1;
            if (month_reg >= 4'd12) begin
               month_next    = 4'd1;
               year_inc_next = 1'b1;
            end else begin
               month_next = month_reg + 4'd1;
            end
         end
      end
   end

   // State registers with synchronous clear to Jan 1.
   always_ff @(posedge clk) begin
      if (clear) begin
         day_reg      <= 5'd1;
         month_reg    <= 4'd1;
         year_inc_reg <= 1'b0;
         load_err_reg <= 1'b0;
      end else begin
         day_reg      <= day_next;
         month_reg    <= month_next;
         year_inc_reg <= year_inc_next;
         load_err_reg <= load_err_next;
      end
   end

   assign day       = day_reg;
   assign month     = month_reg;
   assign year_inc  = year_inc_reg;
   assign load_err  = load_err_reg;
   assign day_bus   = enable ? day_reg : 5'd0;
   assign month_bus = enable ? month_reg : 4'd0;

endmodule

// File: tb/tb_date_month.sv
// Directed bench for date_month: reset, month/year rollover, leap handling,
// load rejection, load/tick priority, clear priority and bus gating.
module tb_date_month;

   logic       clk = 1'b0;
   logic       clear, day_tick, load, enable;
   logic [4:0] load_day;
   logic [3:0] load_month;
   logic [5:0] year;
   logic [4:0] day, day_bus;
   logic [3:0] month, month_bus;
   logic       year_inc, load_err;

   int vectors = 0;
   int errors  = 0;
   int yi_count;

   date_month dut (
      .clk        (clk),
      .clear      (clear),
      .day_tick   (day_tick),
      .load       (load),
      .load_day   (load_day),
      .load_month (load_month),
      .year       (year),
      .enable     (enable),
      .day        (day),
      .month      (month),
      .year_inc   (year_inc),
      .load_err   (load_err),
      .day_bus    (day_bus),
      .month_bus  (month_bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One clock edge; outputs are sampled 1 time unit after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [4:0] d, input logic [3:0] m);
      load = 1'b1; load_day = d; load_month = m;
      step();
      load = 1'b0;
   endtask

   task automatic do_tick();
      day_tick = 1'b1;
      step();
      day_tick = 1'b0;
   endtask

   initial begin
      clear = 1'b1; day_tick = 1'b0; load = 1'b0; enable = 1'b0;
      load_day = 5'd0; load_month = 4'd0; year = 6'd4;
      step();
      clear = 1'b0;
      check("rst_day", 32'(day), 32'd1);
      check("rst_month", 32'(month), 32'd1);
      check("rst_year_inc", 32'(year_inc), 32'd0);
      check("rst_load_err", 32'(load_err), 32'd0);

      // 31 consecutive ticks (held high) from Jan 1 -> Feb 1
      yi_count = 0;
      day_tick = 1'b1;
      for (int i = 0; i < 31; i++) begin
         step();
         if (year_inc) yi_count++;
      end
      day_tick = 1'b0;
      check("jan_day", 32'(day), 32'd1);
      check("jan_month", 32'(month), 32'd2);
      check("jan_no_year_inc", 32'(yi_count), 32'd0);

      // Dec 31 -> Jan 1 with a single year_inc pulse
      do_load(5'd31, 4'd12);
      check("dec_load_day", 32'(day), 32'd31);
      check("dec_load_err", 32'(load_err), 32'd0);
      check("dec_load_no_yi", 32'(year_inc), 32'd0);
      do_tick();
      check("ny_day", 32'(day), 32'd1);
      check("ny_month", 32'(month), 32'd1);
      check("ny_year_inc", 32'(year_inc), 32'd1);
      step();
      check("ny_year_inc_drop", 32'(year_inc), 32'd0);

      // Back-to-back ticks across New Year: pulse only once
      do_load(5'd31, 4'd12);
      day_tick = 1'b1;
      step();
      check("b2b_yi1", 32'(year_inc), 32'd1);
      step();
      day_tick = 1'b0;
      check("b2b_yi2", 32'(year_inc), 32'd0);
      check("b2b_day", 32'(day), 32'd2);

`ifdef LEAP_YEAR_EN
      year = 6'd4;
      do_load(5'd28, 4'd2);
      do_tick();
      check("leap_day29", 32'(day), 32'd29);
      check("leap_month2", 32'(month), 32'd2);
      do_tick();
      check("leap_mar_day", 32'(day), 32'd1);
      check("leap_mar_month", 32'(month), 32'd3);
      year = 6'd5;
      do_load(5'd28, 4'd2);
      do_tick();
      check("nonleap_day", 32'(day), 32'd1);
      check("nonleap_month", 32'(month), 32'd3);
      // Feb 29 loaded in a leap year, then year becomes non-leap
      year = 6'd0;
      do_load(5'd29, 4'd2);
      check("feb29_load_err", 32'(load_err), 32'd0);
      year = 6'd5;
      do_tick();
      check("feb29_stale_day", 32'(day), 32'd1);
      check("feb29_stale_month", 32'(month), 32'd3);
`else
      year = 6'd4;
      do_load(5'd28, 4'd2);
      do_tick();
      check("feb_day", 32'(day), 32'd1);
      check("feb_month", 32'(month), 32'd3);
      do_load(5'd29, 4'd2);
      check("feb29_reject_err", 32'(load_err), 32'd1);
      check("feb29_reject_day", 32'(day), 32'd1);
      check("feb29_reject_month", 32'(month), 32'd3);
`endif

      // Rejected loads: state unchanged, one-cycle load_err
      do_load(5'd15, 4'd6);
      do_load(5'd31, 4'd4);
      check("rej_apr31_err", 32'(load_err), 32'd1);
      check("rej_apr31_day", 32'(day), 32'd15);
      check("rej_apr31_month", 32'(month), 32'd6);
      step();
      check("rej_err_drop", 32'(load_err), 32'd0);
      do_load(5'd0, 4'd5);
      check("rej_day0_err", 32'(load_err), 32'd1);
      do_load(5'd5, 4'd13);
      check("rej_m13_err", 32'(load_err), 32'd1);
      check("rej_m13_day", 32'(day), 32'd15);
      check("rej_m13_month", 32'(month), 32'd6);

      // Load wins over a coincident tick
      load = 1'b1; load_day = 5'd10; load_month = 4'd3; day_tick = 1'b1;
      step();
      load = 1'b0; day_tick = 1'b0;
      check("ldtick_day", 32'(day), 32'd10);
      check("ldtick_month", 32'(month), 32'd3);
      check("ldtick_err", 32'(load_err), 32'd0);

      // 30-day month end
      do_load(5'd30, 4'd4);
      do_tick();
      check("apr30_day", 32'(day), 32'd1);
      check("apr30_month", 32'(month), 32'd5);

      // Clear beats a rollover tick and suppresses year_inc
      do_load(5'd31, 4'd12);
      clear = 1'b1; day_tick = 1'b1;
      step();
      clear = 1'b0; day_tick = 1'b0;
      check("clr_day", 32'(day), 32'd1);
      check("clr_month", 32'(month), 32'd1);
      check("clr_year_inc", 32'(year_inc), 32'd0);
      step();
      check("clr_year_inc_next", 32'(year_inc), 32'd0);

      // Bus gating
      do_load(5'd17, 4'd9);
      enable = 1'b1;
      #1;
      check("bus_on_day", 32'(day_bus), 32'd17);
      check("bus_on_month", 32'(month_bus), 32'd9);
      enable = 1'b0;
      #1;
      check("bus_off_day", 32'(day_bus), 32'd0);
      check("bus_off_month", 32'(month_bus), 32'd0);
      enable = 1'b1;
      #1;
      check("bus_on2_day", 32'(day_bus), 32'd17);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
